spi_bus_arbiter: RTL and testbench

- SPI mode-0 master that shares one SPI bus (sclk/mosi/miso) between NREQ local requesters.
- Each requester owns one dedicated active-low slave select.
- Round-robin arbitration, BITS-wide full-duplex transfers, sclk derived from the system clock by a programmable divider.
- Sits between on-chip clients and the board-level SPI slaves, e.g. the team's SPI slave shift-register blocks.

---
 rtl/spi_arb_pkg.sv | 17 +
 rtl/spi_bus_arbiter_rr.sv | 48 ++++
 rtl/spi_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and width helpers for the SPI bus arbiter
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr.sv
// rtl/spi_bus_arbiter_rr.sv - round-robin winner selection with registered pointer
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_accept,
    output logic [NREQ-1:0] o_win
);
    import spi_arb_pkg::*;

    localparam int PTR_W = cnt_w(NREQ);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_win_idx;
    logic             w_found;
    int               w_idx;

    // Search upward from the pointer with wrap-around; first pending request wins.
    always_comb begin
        o_win     = '0;
        w_win_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && i_req[w_idx]) begin
                w_found       = 1'b1;
                o_win[w_idx]  = 1'b1;
                w_win_idx     = PTR_W'(w_idx);
            end
        end
    end

    // Pointer moves just past the accepted winner so it gets lowest priority next.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_accept && w_found) begin
            r_ptr <= (w_win_idx == PTR_W'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - mode-0 SPI master shared round-robin between requesters
module spi_bus_arbiter #(
    parameter int BITS    = 8,
    parameter int NREQ    = 4,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*BITS-1:0] i_tx_data,
    output logic [NREQ-1:0]      o_grant,
    output logic [NREQ-1:0]      o_done,
    output logic [BITS-1:0]      o_rx_data,
    output logic                 o_busy,
    output logic                 o_sclk,
    output logic [NREQ-1:0]      o_ss_n,
    output logic                 o_mosi,
    input  logic                 i_miso
);
    import spi_arb_pkg::*;

    localparam int DIV_W  = cnt_w(CLK_DIV);
    localparam int EDGE_W = cnt_w(2 * BITS + 1);
    localparam int GAP_W  = cnt_w(CS_GAP);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [EDGE_W-1:0] r_edge_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [BITS-1:0]   r_tx_sh;
    logic [BITS-1:0]   r_rx_sh;
    logic [BITS-1:0]   r_rx_data;
    logic [BITS-1:0]   w_tx_word;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;
    logic [NREQ-1:0]   r_ss_n;
    logic [NREQ-1:0]   w_win;
    logic              r_sclk;
    logic              r_mosi;
    logic              w_tick;
    logic              w_last_edge;
    logic              w_gap_end;
    logic              w_accept;

    assign w_tick      = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_last_edge = (r_edge_cnt == EDGE_W'(2 * BITS - 1));
    assign w_gap_end   = (r_gap_cnt == GAP_W'(CS_GAP - 1));
    assign w_accept    = (r_state == IDLE) && (|i_req);

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (i_req),
        .i_accept (w_accept),
        .o_win    (w_win)
    );

    // Pick the winner's transmit word out of the packed request bus.
    always_comb begin
        w_tx_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win[i]) begin
                w_tx_word = i_tx_data[i*BITS +: BITS];
            end
        end
    end

    // Phase sequencing: select asserted, clocking, hold before deselect, inter-transfer gap.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|i_req)                w_state_nxt = SETUP;
            SETUP:   if (w_tick)                w_state_nxt = SHIFT;
            SHIFT:   if (w_tick && w_last_edge) w_state_nxt = HOLD;
            HOLD:    if (w_tick)                w_state_nxt = GAP;
            GAP:     if (w_gap_end)             w_state_nxt = IDLE;
            default:                            w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Divider, edge counting, shift registers and registered bus outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_gap_cnt  <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_ss_n     <= '1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_done <= '0;
            if (r_state == SETUP || r_state == SHIFT || r_state == HOLD) begin
                r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            end else begin
                r_div_cnt <= '0;
            end
            r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 1'b1 : '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_grant    <= w_win;
                        r_ss_n     <= ~w_win;
                        r_tx_sh    <= w_tx_word;
                        r_mosi     <= w_tx_word[BITS-1];
                        r_sclk     <= 1'b0;
                        r_edge_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_sclk     <= 1'b1;
                        r_rx_sh    <= {r_rx_sh[BITS-2:0], i_miso};
                        r_edge_cnt <= EDGE_W'(1);
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                        if (!r_sclk) begin
                            r_rx_sh <= {r_rx_sh[BITS-2:0], i_miso};
                        end else if (w_last_edge) begin
                            r_mosi <= 1'b0;
                        end else begin
                            r_mosi  <= r_tx_sh[BITS-2];
                            r_tx_sh <= {r_tx_sh[BITS-2:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_ss_n    <= '1;
                        r_grant   <= '0;
                        r_done    <= r_grant;
                        r_rx_data <= r_rx_sh;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_grant   = r_grant;
    assign o_done    = r_done;
    assign o_rx_data = r_rx_data;
    assign o_busy    = (r_state != IDLE);
    assign o_sclk    = r_sclk;
    assign o_ss_n    = r_ss_n;
    assign o_mosi    = r_mosi;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - self-checking bench for spi_bus_arbiter
module tb_spi_bus_arbiter;

    localparam int BITS    = 8;
    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 2;
    localparam int T_XFER  = 1 + (2 * BITS + 1) * CLK_DIV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    logic        rst;
    logic [3:0]  req;
    logic [31:0] tx_data;
    logic [3:0]  grant, done, ss_n;
    logic [7:0]  rx_data;
    logic        busy, sclk, mosi, miso;

    logic [1:0]  b_req;
    logic [7:0]  b_tx;
    logic [1:0]  b_grant, b_done, b_ss_n;
    logic [3:0]  b_rx;
    logic        b_busy, b_sclk, b_mosi, b_miso;

    spi_bus_arbiter #(.BITS(8), .NREQ(4), .CLK_DIV(4), .CS_GAP(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_tx_data(tx_data),
        .o_grant(grant), .o_done(done), .o_rx_data(rx_data), .o_busy(busy),
        .o_sclk(sclk), .o_ss_n(ss_n), .o_mosi(mosi), .i_miso(miso)
    );

    spi_bus_arbiter #(.BITS(4), .NREQ(2), .CLK_DIV(1), .CS_GAP(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(b_req), .i_tx_data(b_tx),
        .o_grant(b_grant), .o_done(b_done), .o_rx_data(b_rx), .o_busy(b_busy),
        .o_sclk(b_sclk), .o_ss_n(b_ss_n), .o_mosi(b_mosi), .i_miso(b_miso)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mode-0 slave models: present MSB on select, advance after each falling sclk.
    logic [7:0] s_word = '0;
    logic       s_bit = 1'b0, s_ps = 1'b0, loop_en = 1'b0;
    int         s_idx = 0;
    assign miso = loop_en ? mosi : s_bit;
    always @(negedge clk) begin
        if (&ss_n) s_idx = 0;
        else if (s_ps && !sclk) s_idx = s_idx + 1;
        s_bit = (s_idx < 8) ? s_word[7 - s_idx] : 1'b0;
        s_ps  = sclk;
    end

    logic [3:0] bs_word = '0;
    logic       bs_bit = 1'b0, bs_ps = 1'b0;
    int         bs_idx = 0;
    assign b_miso = bs_bit;
    always @(negedge clk) begin
        if (&b_ss_n) bs_idx = 0;
        else if (bs_ps && !b_sclk) bs_idx = bs_idx + 1;
        bs_bit = (bs_idx < 4) ? bs_word[3 - bs_idx] : 1'b0;
        bs_ps  = b_sclk;
    end

    // At most one slave select may ever be low.
    always @(negedge clk) begin
        chk("ss_onehot_a", 64'($countones(~ss_n) <= 1), 64'd1);
        chk("ss_onehot_b", 64'($countones(~b_ss_n) <= 1), 64'd1);
    end

    // Reference round-robin: first pending index at or above the pointer, wrapping.
    function automatic int rr_pick(input logic [3:0] pend, input int p);
        for (int k = 0; k < 4; k++) begin
            if (pend[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Follow a transfer until a done pulse; record mosi at each sclk rise.
    task automatic watch(input int budget, input int drop_cyc, input logic [3:0] drop_mask,
                         output int who, output int dcyc, output logic [7:0] mw, output logic [7:0] rx);
        logic ps;
        ps = sclk; who = -1; dcyc = -1; mw = '0; rx = '0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (cyc == drop_cyc) req = req & ~drop_mask;
            if (sclk && !ps) mw = {mw[6:0], mosi};
            ps = sclk;
            if (|done) begin
                for (int i = 0; i < 4; i++) if (done[i]) who = i;
                dcyc = cyc;
                rx   = rx_data;
                break;
            end
        end
    endtask

    int         t0, who, dcyc, w, exp_d, ptr_m, gap;
    logic [7:0] mw, rx, exp_w, exp_rx;
    logic [3:0] pend, bmw;
    int         b_rise1, b_rise2, b_dcyc;
    logic       bps;

    initial begin
        rst = 1'b1; req = '0; tx_data = '0; b_req = '0; b_tx = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_ss_n", ss_n, 4'hF);
        chk("rst_mosi", mosi, 0);
        chk("rst_b_ss_n", b_ss_n, 2'b11);
        rst = 1'b0;

        // Single transfer through requester 2.
        tx_data = 32'h11A52233;
        s_word  = 8'h3C;
        @(negedge clk);
        t0 = cyc; req = 4'b0100;
        @(negedge clk);
        chk("t1_ss_n", ss_n, 4'b1011);
        chk("t1_grant", grant, 4'b0100);
        chk("t1_mosi_msb", mosi, 1);
        chk("t1_sclk", sclk, 0);
        chk("t1_busy", busy, 1);
        watch(150, -1, 4'b0, who, dcyc, mw, rx);
        chk("t1_who", who, 2);
        chk("t1_done_cyc", dcyc, t0 + T_XFER);
        chk("t1_mosi_bits", mw, 8'hA5);
        chk("t1_rx", rx, 8'h3C);
        chk("t1_ss_n_end", ss_n, 4'hF);
        req = '0;

        // Simultaneous requests right after reset.
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        ptr_m = 0; pend = 4'b1010;
        tx_data = $urandom; s_word = 8'($urandom);
        @(negedge clk);
        t0 = cyc; req = pend; exp_d = t0 + T_XFER;
        for (int n = 0; n < 2; n++) begin
            w = rr_pick(pend, ptr_m); ptr_m = (w + 1) % 4;
            exp_w = tx_data[w*8 +: 8]; exp_rx = s_word;
            watch(150, -1, 4'b0, who, dcyc, mw, rx);
            chk("t2_who", who, w);
            chk("t2_done_cyc", dcyc, exp_d);
            chk("t2_mosi", mw, exp_w);
            chk("t2_rx", rx, exp_rx);
            pend[w] = 1'b0; req = pend;
            s_word = 8'($urandom);
            exp_d = exp_d + CS_GAP + T_XFER;
            if (n == 0) begin
                gap = 0;
                do begin @(negedge clk); gap++; end while (&ss_n && gap < 20);
                chk("t2_cs_gap", gap, CS_GAP + 1);
            end
        end
        repeat (6) @(negedge clk);

        // Fairness with all four requesting continuously.
        pend = 4'hF; tx_data = $urandom; s_word = 8'($urandom);
        t0 = cyc; req = pend; exp_d = t0 + T_XFER;
        for (int n = 0; n < 8; n++) begin
            w = rr_pick(pend, ptr_m); ptr_m = (w + 1) % 4;
            exp_w = tx_data[w*8 +: 8]; exp_rx = s_word;
            watch(150, -1, 4'b0, who, dcyc, mw, rx);
            chk("fair_who", who, w);
            chk("fair_done_cyc", dcyc, exp_d);
            chk("fair_mosi", mw, exp_w);
            chk("fair_rx", rx, exp_rx);
            exp_d = exp_d + CS_GAP + T_XFER;
            tx_data = $urandom; s_word = 8'($urandom);
        end
        req = '0;
        repeat (6) @(negedge clk);

        // Reset in the middle of a transfer.
        pend = 4'b0010; w = rr_pick(pend, ptr_m); ptr_m = (w + 1) % 4;
        t0 = cyc; req = pend;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ss_n", ss_n, 4'hF);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_mosi", mosi, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_grant", grant, 0);
        rst = 1'b0; ptr_m = 0; pend = 4'b1101;
        s_word = 8'($urandom); exp_rx = s_word;
        w = rr_pick(pend, ptr_m); ptr_m = (w + 1) % 4;
        t0 = cyc; req = pend;
        watch(150, -1, 4'b0, who, dcyc, mw, rx);
        chk("post_rst_who", who, w);
        chk("post_rst_done_cyc", dcyc, t0 + T_XFER);
        chk("post_rst_rx", rx, exp_rx);
        req = '0;
        repeat (6) @(negedge clk);

        // Loopback with the request dropped early.
        loop_en = 1'b1; tx_data = {24'($urandom), 8'hFF};
        pend = 4'b0001; w = rr_pick(pend, ptr_m); ptr_m = (w + 1) % 4;
        t0 = cyc; req = pend;
        watch(150, t0 + 10, 4'b0001, who, dcyc, mw, rx);
        chk("loop_who", who, w);
        chk("loop_done_cyc", dcyc, t0 + T_XFER);
        chk("loop_rx", rx, 8'hFF);
        chk("loop_mosi", mw, 8'hFF);
        repeat (CS_GAP + 2) @(negedge clk);
        chk("loop_idle_busy", busy, 0);
        chk("loop_idle_ss_n", ss_n, 4'hF);
        loop_en = 1'b0;

        // Narrow build: four bits, one clk per sclk half-period.
        b_tx = {4'h6, 4'h9}; bs_word = 4'($urandom);
        t0 = cyc; b_req = 2'b01;
        @(negedge clk);
        chk("b_ss_n", b_ss_n, 2'b10);
        bps = b_sclk; bmw = '0; b_rise1 = -1; b_rise2 = -1; b_dcyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (b_sclk && !bps) begin
                bmw = {bmw[2:0], b_mosi};
                if (b_rise1 < 0) b_rise1 = cyc;
                else if (b_rise2 < 0) b_rise2 = cyc;
            end
            bps = b_sclk;
            if (|b_done) begin
                b_dcyc = cyc;
                chk("b_done_vec", b_done, 2'b01);
                chk("b_rx", b_rx, bs_word);
                break;
            end
        end
        b_req = '0;
        chk("b_rise1", b_rise1, t0 + 2);
        chk("b_period", b_rise2 - b_rise1, 2);
        chk("b_done_cyc", b_dcyc, t0 + 10);
        chk("b_mosi", bmw, 4'h9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
